pipe_stage_chain: RTL

//  Parametrised N-stage valid/ready pipeline register chain for the MCS8 core.
//  It replaces the hand-written F1->F2->F3->D stage copies with one generic

---
 rtl/pipe_stage_chain.sv | 105 ++++++++++
 1 files changed

// File: rtl/pipe_stage_chain.sv
// Parametrised N-stage valid/ready register chain with flush and occupancy count.
// Optional macro PIPE_BUBBLE_COLLAPSE_EN selects a per-stage ready chain (bubble squeeze).
module pipe_stage_chain #(
  parameter int DW    = 8,
  parameter int DEPTH = 3,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             CLK_I,
  input  logic             nRST_I,
  input  logic             IN_VALID_I,
  input  logic [DW-1:0]    IN_DATA_I,
  output logic             IN_READY_O,
  output logic             OUT_VALID_O,
  output logic [DW-1:0]    OUT_DATA_O,
  input  logic             OUT_READY_I,
  input  logic             FLUSH_I,
  output logic [DEPTH-1:0] STAGE_VALID_O,
  output logic [CW-1:0]    COUNT_O
);

  logic [DEPTH-1:0] r_v;
  logic [DW-1:0]    r_d [DEPTH];

  logic [DEPTH-1:0] w_v_in;
  logic [DW-1:0]    w_d_in [DEPTH];
  logic [DEPTH-1:0] w_load;
  logic [CW-1:0]    w_cnt;

  // Feed of each stage: stage 0 takes the upstream port, stage i the stage before it.
  for (genvar g = 0; g < DEPTH; g++) begin : g_feed
    if (g == 0) begin : g_head
      assign w_v_in[g] = IN_VALID_I;
      assign w_d_in[g] = IN_DATA_I;
    end else begin : g_body
      assign w_v_in[g] = r_v[g-1];
      assign w_d_in[g] = r_d[g-1];
    end
  end

`ifdef PIPE_BUBBLE_COLLAPSE_EN
  logic [DEPTH-1:0] w_rdy;

  // Ready ripples backwards; an empty stage is always ready, so bubbles are squeezed out.
  always_comb begin
    w_rdy            = '0;
    w_rdy[DEPTH-1]   = OUT_READY_I | ~r_v[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_rdy[i] = w_rdy[i+1] | ~r_v[i];
    end
  end

  assign w_load = w_rdy;
`else
  logic w_adv;

  // Global stall: the whole chain moves together, bubbles included.
  assign w_adv  = OUT_READY_I | ~r_v[DEPTH-1];
  assign w_load = {DEPTH{w_adv}};
`endif

  // Valid bits: flush clears every stage and overrides any load.
  always_ff @(posedge CLK_I or negedge nRST_I) begin
    if (!nRST_I) begin
      r_v <= '0;
    end else if (FLUSH_I) begin
      r_v <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_load[i]) begin
          r_v[i] <= w_v_in[i];
        end
      end
    end
  end

  // Data registers load with their stage regardless of valid; a flush freezes them.
  always_ff @(posedge CLK_I or negedge nRST_I) begin
    if (!nRST_I) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_d[i] <= '0;
      end
    end else if (!FLUSH_I) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_load[i]) begin
          r_d[i] <= w_d_in[i];
        end
      end
    end
  end

  // Occupancy is the popcount of the raw stage valid bits.
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cnt = w_cnt + CW'(r_v[i]);
    end
  end

  assign IN_READY_O    = w_load[0] & ~FLUSH_I;
  assign OUT_VALID_O   = r_v[DEPTH-1] & ~FLUSH_I;
  assign OUT_DATA_O    = r_d[DEPTH-1];
  assign STAGE_VALID_O = r_v;
  assign COUNT_O       = w_cnt;

endmodule
